// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter slice: FSM states, owner codes, bus widths
// and the byte-enable selection helper.
package sram_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam sel_t SEL_ALL = '1;

  // Fetch always reads whole words; only the data requester narrows the enables.
  function automatic sel_t grant_sel(input owner_e owner, input sel_t mem_sel);
    return (owner == OWNER_MEM) ? mem_sel : SEL_ALL;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the pipeline requesters, the SRAM arbiter and the SRAM pins.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
) ();
  import sram_arbiter_pkg::*;

  logic              if_req_i;
  logic [31:0]       if_addr_i;
  word_t             if_rdata_o;
  logic              if_ack_o;

  logic              mem_req_i;
  logic              mem_we_i;
  sel_t              mem_sel_i;
  logic [31:0]       mem_addr_i;
  word_t             mem_wdata_i;
  word_t             mem_rdata_o;
  logic              mem_ack_o;

  logic              sram_ce_o;
  logic              sram_we_o;
  sel_t              sram_sel_o;
  logic [ADDR_W-1:0] sram_addr_o;
  word_t             sram_wdata_o;
  word_t             sram_rdata_i;

  logic              stallreq_if_o;
  logic              stallreq_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ack_o,
    output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o,
    input  sram_rdata_i,
    output stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ack_o,
    input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o,
    output sram_rdata_i,
    input  stallreq_if_o, stallreq_mem_o
  );

endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data memory, one access at a time.
// Build macro ARB_ROUND_ROBIN_EN alternates the grant on collisions instead of fixed MEM priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  owner_e            r_owner;
  owner_e            w_owner_nxt;

  logic              w_any_req;
  logic              w_grant;
  logic              w_pick_mem;
  logic              w_final;
  logic              w_ack_ok;
  logic              w_if_ack;
  logic              w_mem_ack;

  logic              r_ce;
  logic              r_we;
  sel_t              r_sel;
  logic [ADDR_W-1:0] r_addr;
  word_t             r_wdata;

  logic              w_unused;

  // Byte-offset and above-range address bits are deliberately dropped.
  assign w_unused  = ^{bus.if_addr_i, bus.mem_addr_i};

  assign w_any_req = bus.if_req_i | bus.mem_req_i;
  assign w_final   = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= OWNER_IF;
    end else if (w_final) begin
      r_last_owner <= r_owner;
    end
  end

  always_comb begin
    w_pick_mem = bus.mem_req_i;
    if (bus.mem_req_i && bus.if_req_i) begin
      w_pick_mem = (r_last_owner == OWNER_IF);
    end
  end
`else
  // The data stage is older, so it always wins a collision.
  assign w_pick_mem = bus.mem_req_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_owner <= OWNER_IF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_grant     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = WAIT_INIT;
          w_owner_nxt = w_pick_mem ? OWNER_MEM : OWNER_IF;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM pins are registered: loaded at grant, cleared on the edge that leaves ACCESS.
  always_ff @(posedge clk) begin
    if (rst || w_final) begin
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_ce <= 1'b1;
      if (w_pick_mem) begin
        r_we    <= bus.mem_we_i;
        r_sel   <= grant_sel(OWNER_MEM, bus.mem_sel_i);
        r_addr  <= bus.mem_addr_i[ADDR_W+1:2];
        r_wdata <= bus.mem_wdata_i;
      end else begin
        r_we    <= 1'b0;
        r_sel   <= grant_sel(OWNER_IF, bus.mem_sel_i);
        r_addr  <= bus.if_addr_i[ADDR_W+1:2];
        r_wdata <= '0;
      end
    end
  end

  assign bus.sram_ce_o    = r_ce;
  assign bus.sram_we_o    = r_we;
  assign bus.sram_sel_o   = r_sel;
  assign bus.sram_addr_o  = r_addr;
  assign bus.sram_wdata_o = r_wdata;

  // A withdrawn request (e.g. flushed fetch) still finishes its access but gets no ack.
  assign w_ack_ok  = w_final & ~rst;
  assign w_if_ack  = w_ack_ok & (r_owner == OWNER_IF)  & bus.if_req_i;
  assign w_mem_ack = w_ack_ok & (r_owner == OWNER_MEM) & bus.mem_req_i;

  assign bus.if_ack_o    = w_if_ack;
  assign bus.mem_ack_o   = w_mem_ack;
  assign bus.if_rdata_o  = w_if_ack  ? bus.sram_rdata_i : '0;
  assign bus.mem_rdata_o = w_mem_ack ? bus.sram_rdata_i : '0;

  assign bus.stallreq_if_o  = bus.if_req_i  & ~w_if_ack;
  assign bus.stallreq_mem_o = bus.mem_req_i & ~w_mem_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter: a transaction-level model predicts each
// granted access and a negedge monitor compares every SRAM pin, ack, rdata and stall.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int W  = 1;
  localparam int AW = 20;
  localparam int NW = 128;

  typedef struct {
    bit          own_mem;
    int          first_cyc;
    int          ack_cyc;
    logic [31:0] rdata;
    bit          we;
    logic [3:0]  sel;
    logic [AW-1:0] waddr;
    logic [31:0] wdata;
  } acc_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst0 = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();
  sram_arbiter_if #(.ADDR_W(AW)) bus0 ();

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  sram_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          m_busy_until = -1;
  bit          m_last_mem = 1'b0;
  bit          m_cur_mem = 1'b0;
  acc_t        sbq[$];
  logic [31:0] ref_mem [NW];
  logic [31:0] sram_mem [NW];

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h41) return 32'h2408_0005;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM device model
  initial begin : sram_model
    for (int i = 0; i < NW; i++) sram_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.sram_ce_o && bus.sram_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.sram_sel_o[b]) sram_mem[bus.sram_addr_o[6:0]][8*b +: 8] = bus.sram_wdata_o[8*b +: 8];
    end
  end
  assign bus.sram_rdata_i  = sram_mem[bus.sram_addr_o[6:0]];
  assign bus0.sram_rdata_i = 32'hCAFE_F00D;

  // Reference model: one access at a time, granted in an idle cycle, lasting W+1 cycles.
  initial begin : ref_model
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (rst) begin
        if (m_busy_until >= cyc) m_busy_until = cyc;
        m_last_mem = 1'b0;
      end else if (cyc > m_busy_until && (bus.if_req_i || bus.mem_req_i)) begin
        acc_t a;
        bit   pick_mem;
        int   idx;
`ifdef ARB_ROUND_ROBIN_EN
        pick_mem = (bus.if_req_i && bus.mem_req_i) ? !m_last_mem : bus.mem_req_i;
`else
        pick_mem = bus.mem_req_i;
`endif
        a.own_mem   = pick_mem;
        a.first_cyc = cyc + 1;
        a.ack_cyc   = cyc + 1 + W;
        if (pick_mem) begin
          a.we = bus.mem_we_i; a.sel = bus.mem_sel_i;
          a.waddr = AW'(bus.mem_addr_i >> 2); a.wdata = bus.mem_wdata_i;
        end else begin
          a.we = 1'b0; a.sel = 4'hF;
          a.waddr = AW'(bus.if_addr_i >> 2); a.wdata = 32'd0;
        end
        idx = int'(a.waddr) % NW;
        a.rdata = ref_mem[idx];
        if (a.we)
          for (int b = 0; b < 4; b++)
            if (a.sel[b]) ref_mem[idx][8*b +: 8] = a.wdata[8*b +: 8];
        sbq.push_back(a);
        m_busy_until = a.ack_cyc;
        m_cur_mem    = pick_mem;
      end else if (cyc == m_busy_until) begin
        m_last_mem = m_cur_mem;
      end
      cyc++;
    end
  end

  task automatic check_cycle();
    acc_t e;
    bit   act, fin, xif, xmem;
    act = 1'b0;
    e   = '{default: 0};
    if (sbq.size() > 0 && sbq[0].first_cyc <= cyc && cyc <= sbq[0].ack_cyc) begin
      act = 1'b1;
      e   = sbq[0];
    end
    fin  = act && (cyc == e.ack_cyc);
    xif  = fin && !e.own_mem && bus.if_req_i && !rst;
    xmem = fin && e.own_mem && bus.mem_req_i && !rst;
    chk("sram_ce", 32'(bus.sram_ce_o), 32'(act));
    chk("sram_we", 32'(bus.sram_we_o), 32'(act && e.own_mem && e.we));
    chk("sram_sel", 32'(bus.sram_sel_o), act ? 32'(e.sel) : 32'd0);
    chk("sram_addr", 32'(bus.sram_addr_o), act ? 32'(e.waddr) : 32'd0);
    chk("sram_wdata", bus.sram_wdata_o, act ? e.wdata : 32'd0);
    chk("if_ack", 32'(bus.if_ack_o), 32'(xif));
    chk("mem_ack", 32'(bus.mem_ack_o), 32'(xmem));
    chk("if_rdata", bus.if_rdata_o, xif ? e.rdata : 32'd0);
    if (!(xmem && e.we)) chk("mem_rdata", bus.mem_rdata_o, xmem ? e.rdata : 32'd0);
    chk("stall_if", 32'(bus.stallreq_if_o), 32'(bus.if_req_i && !xif));
    chk("stall_mem", 32'(bus.stallreq_mem_o), 32'(bus.mem_req_i && !xmem));
    if (act && (fin || rst)) void'(sbq.pop_front());
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  task automatic wait_ack(input bit is_mem);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (is_mem ? bus.mem_ack_o : bus.if_ack_o) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout requester=%0d cyc=%0d got=no-ack want=ack", is_mem, cyc);
    end
    tick();
    if (is_mem) bus.mem_req_i = 1'b0;
    else        bus.if_req_i  = 1'b0;
  endtask

  task automatic if_access(input logic [31:0] addr);
    bus.if_addr_i = addr;
    bus.if_req_i  = 1'b1;
    wait_ack(1'b0);
  endtask

  task automatic mem_access(input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.mem_we_i    = we;
    bus.mem_sel_i   = sel;
    bus.mem_addr_i  = addr;
    bus.mem_wdata_i = wdata;
    bus.mem_req_i   = 1'b1;
    wait_ack(1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    return {10'($urandom), 13'd0, 7'($urandom_range(0, NW - 1)), 2'($urandom)};
  endfunction

  // Zero-wait-state instance: a held fetch request is acked every second cycle.
  initial begin : w0_check
    bus0.if_req_i = 1'b0; bus0.if_addr_i = 32'h0000_0104;
    bus0.mem_req_i = 1'b0; bus0.mem_we_i = 1'b0; bus0.mem_sel_i = 4'h0;
    bus0.mem_addr_i = 32'd0; bus0.mem_wdata_i = 32'd0;
    repeat (3) tick();
    rst0 = 1'b0;
    bus0.if_req_i = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("w0_ce", 32'(bus0.sram_ce_o), 32'(j % 2));
      chk("w0_if_ack", 32'(bus0.if_ack_o), 32'(j % 2));
      chk("w0_if_rdata", bus0.if_rdata_o, (j % 2 == 1) ? 32'hCAFE_F00D : 32'd0);
      chk("w0_addr", 32'(bus0.sram_addr_o), (j % 2 == 1) ? 32'h41 : 32'd0);
    end
    bus0.if_req_i = 1'b0;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_sel_i = 4'h0;
    bus.mem_addr_i = 32'd0; bus.mem_wdata_i = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    if_access(32'h0000_0104);
    tick();

    mem_access(1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF);
    mem_access(1'b0, 4'hF, 32'h0000_0010, 32'd0);

    fork
      if_access(32'h0000_0020);
      mem_access(1'b0, 4'hF, 32'h0000_0030, 32'd0);
    join
    tick();

    // Reset lands in the first ACCESS cycle of a write.
    bus.mem_we_i = 1'b1; bus.mem_sel_i = 4'hF;
    bus.mem_addr_i = 32'h0000_0044; bus.mem_wdata_i = 32'h5555_AAAA;
    bus.mem_req_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_req_i = 1'b0;
    repeat (2) tick();

    // Fetch withdrawn mid-access while a data read waits.
    bus.if_addr_i = 32'h0000_0108;
    bus.if_req_i  = 1'b1;
    tick();
    bus.mem_we_i = 1'b0; bus.mem_sel_i = 4'hF;
    bus.mem_addr_i = 32'h0000_0044; bus.mem_req_i = 1'b1;
    tick();
    bus.if_req_i = 1'b0;
    wait_ack(1'b1);
    tick();

    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          if_access(rand_addr());
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          mem_access(1'($urandom), 4'($urandom_range(1, 15)), rand_addr(), $urandom);
        end
      end
    join

    repeat (5) tick();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
